// File: rtl/partial_pagerank_gen_if.sv
// Read port between the partial-pagerank producer and the source-node store.
// The producer issues a one-cycle request and the store answers with one valid beat.
interface partial_pagerank_gen_if #(
    parameter int DW   = 32,
    parameter int DEGW = 8
);
    logic            rd_req;
    logic [3:0]      rd_idx;
    logic            rd_valid;
    logic [DW-1:0]   rd_pagerank;
    logic [DEGW-1:0] rd_outdeg;

    modport master (
        output rd_req,
        output rd_idx,
        input  rd_valid,
        input  rd_pagerank,
        input  rd_outdeg
    );

    modport slave (
        input  rd_req,
        input  rd_idx,
        output rd_valid,
        output rd_pagerank,
        output rd_outdeg
    );
endinterface

// File: rtl/partial_pagerank_gen.sv
// Computes floor(pagerank_j / outdeg_j) for the ten possible sources of one destination,
// fetching each linked source over the read port and sharing one bit-serial divider.
module partial_pagerank_gen #(
    parameter int DW   = 32,
    parameter int DEGW = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [9:0]              adj_mask,
    partial_pagerank_gen_if.master  rd,
    output logic                    busy,
    output logic                    done,
    output logic                    deg_err,
    output logic [DW-1:0]           partial_pagerank_0,
    output logic [DW-1:0]           partial_pagerank_1,
    output logic [DW-1:0]           partial_pagerank_2,
    output logic [DW-1:0]           partial_pagerank_3,
    output logic [DW-1:0]           partial_pagerank_4,
    output logic [DW-1:0]           partial_pagerank_5,
    output logic [DW-1:0]           partial_pagerank_6,
    output logic [DW-1:0]           partial_pagerank_7,
    output logic [DW-1:0]           partial_pagerank_8,
    output logic [DW-1:0]           partial_pagerank_9
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DIV   = 3'd3;
    localparam logic [2:0] S_STORE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int CW = $clog2(DW);

    logic [2:0]      state;
    logic [3:0]      idx;
    logic [9:0]      mask_q;
    logic [DW-1:0]   quot;
    logic [DEGW-1:0] divisor;
    logic [DEGW-1:0] rem;
    logic [CW-1:0]   bit_cnt;
    logic [DW-1:0]   partial [10];

    logic [DEGW:0]   rem_shift;
    logic [DEGW:0]   diff;
    logic            rem_ge;
    logic            last_idx;
    logic [2:0]      adv_state;
    logic [3:0]      adv_idx;

    // rem < divisor always holds, so the trial difference fits DEGW+1 bits and its sign is the borrow.
    always_comb begin
        rem_shift = {rem, quot[DW-1]};
        diff      = rem_shift - {1'b0, divisor};
        rem_ge    = ~diff[DEGW];
        last_idx  = (idx == 4'd9);
        adv_state = last_idx ? S_DONE : S_REQ;
        adv_idx   = last_idx ? idx : idx + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            idx     <= 4'd0;
            mask_q  <= 10'd0;
            quot    <= '0;
            divisor <= '0;
            rem     <= '0;
            bit_cnt <= '0;
            deg_err <= 1'b0;
            for (int k = 0; k < 10; k++) partial[k] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mask_q  <= adj_mask;
                        idx     <= 4'd0;
                        deg_err <= 1'b0;
                        for (int k = 0; k < 10; k++) partial[k] <= '0;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mask_q[idx]) begin
                        state <= S_WAIT;
                    end else begin
                        partial[idx] <= '0;
                        state        <= adv_state;
                        idx          <= adv_idx;
                    end
                end
                S_WAIT: begin
                    if (rd.rd_valid) begin
                        quot    <= rd.rd_pagerank;
                        divisor <= rd.rd_outdeg;
                        rem     <= '0;
                        bit_cnt <= '0;
                        if (rd.rd_outdeg == '0) begin
                            partial[idx] <= '0;
                            deg_err      <= 1'b1;
                            state        <= adv_state;
                            idx          <= adv_idx;
                        end else begin
                            state <= S_DIV;
                        end
                    end
                end
                // Quotient bits shift in at the bottom as dividend bits shift out of the top.
                S_DIV: begin
                    quot    <= {quot[DW-2:0], rem_ge};
                    rem     <= rem_ge ? diff[DEGW-1:0] : rem_shift[DEGW-1:0];
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == CW'(DW - 1)) state <= S_STORE;
                end
                S_STORE: begin
                    partial[idx] <= quot;
                    state        <= adv_state;
                    idx          <= adv_idx;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign rd.rd_req = (state == S_REQ) && mask_q[idx];
    assign rd.rd_idx = idx;

    assign partial_pagerank_0 = partial[0];
    assign partial_pagerank_1 = partial[1];
    assign partial_pagerank_2 = partial[2];
    assign partial_pagerank_3 = partial[3];
    assign partial_pagerank_4 = partial[4];
    assign partial_pagerank_5 = partial[5];
    assign partial_pagerank_6 = partial[6];
    assign partial_pagerank_7 = partial[7];
    assign partial_pagerank_8 = partial[8];
    assign partial_pagerank_9 = partial[9];

endmodule

// File: tb/tb_partial_pagerank_gen.sv
// Directed bench for partial_pagerank_gen: a small source-store model answers reads
// with per-source latency, and each pass is checked against hand-computed results.
module tb_partial_pagerank_gen;

    localparam int DW   = 32;
    localparam int DEGW = 8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [9:0] adj_mask;
    logic       busy;
    logic       done;
    logic       deg_err;
    wire [DW-1:0] pp [10];

    partial_pagerank_gen_if #(.DW(DW), .DEGW(DEGW)) rd_bus ();

    partial_pagerank_gen #(.DW(DW), .DEGW(DEGW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .adj_mask           (adj_mask),
        .rd                 (rd_bus.master),
        .busy               (busy),
        .done               (done),
        .deg_err            (deg_err),
        .partial_pagerank_0 (pp[0]),
        .partial_pagerank_1 (pp[1]),
        .partial_pagerank_2 (pp[2]),
        .partial_pagerank_3 (pp[3]),
        .partial_pagerank_4 (pp[4]),
        .partial_pagerank_5 (pp[5]),
        .partial_pagerank_6 (pp[6]),
        .partial_pagerank_7 (pp[7]),
        .partial_pagerank_8 (pp[8]),
        .partial_pagerank_9 (pp[9])
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [DW-1:0]   pr_tab  [10];
    logic [DEGW-1:0] deg_tab [10];
    int              lat_tab [10];
    int              req_seen;
    int              first_req_cycle;
    logic [3:0]      first_req_idx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Source store: answers each request rd latency cycles after the request cycle.
    initial begin
        rd_bus.rd_valid    = 1'b0;
        rd_bus.rd_pagerank = '0;
        rd_bus.rd_outdeg   = '0;
        forever begin
            @(negedge clk);
            if (rd_bus.rd_req === 1'b1) begin
                int j;
                j = int'(rd_bus.rd_idx);
                req_seen++;
                repeat (lat_tab[j]) @(posedge clk);
                #1;
                rd_bus.rd_valid    = 1'b1;
                rd_bus.rd_pagerank = pr_tab[j];
                rd_bus.rd_outdeg   = deg_tab[j];
                @(posedge clk);
                #1;
                rd_bus.rd_valid = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] orPartials();
        logic [DW-1:0] acc = '0;
        for (int k = 0; k < 10; k++) acc |= pp[k];
        return acc;
    endfunction

    function automatic logic [63:0] sumPartials();
        logic [63:0] acc = '0;
        for (int k = 0; k < 10; k++) acc += 64'(pp[k]);
        return acc;
    endfunction

    task automatic setTables(input logic [DW-1:0] pr, input logic [DEGW-1:0] deg, input int lat);
        for (int k = 0; k < 10; k++) begin
            pr_tab[k]  = pr;
            deg_tab[k] = deg;
            lat_tab[k] = lat;
        end
    endtask

    // Starts a pass in cycle 0, flips adj_mask right after acceptance and returns the done cycle.
    task automatic applyStimulus(input logic [9:0] mask, input bit pulse_busy_start, output int done_cycle);
        int cyc;
        @(posedge clk);
        #1;
        adj_mask        = mask;
        start           = 1'b1;
        req_seen        = 0;
        first_req_cycle = -1;
        first_req_idx   = 4'hF;
        @(posedge clk);
        #1;
        start      = 1'b0;
        adj_mask   = ~mask;
        cyc        = 1;
        done_cycle = -1;
        while (cyc < 2000) begin
            if (rd_bus.rd_req === 1'b1 && first_req_cycle < 0) begin
                first_req_cycle = cyc;
                first_req_idx   = rd_bus.rd_idx;
            end
            if (done === 1'b1) begin
                done_cycle = cyc;
                break;
            end
            start = pulse_busy_start && (cyc == 10 || cyc == 20);
            @(posedge clk);
            #1;
            cyc++;
        end
        start    = 1'b0;
        adj_mask = 10'd0;
    endtask

    logic [DW-1:0] exp_div3 [10] = '{32'd333, 32'd666, 32'd1000, 32'd1333, 32'd1666,
                                     32'd2000, 32'd2333, 32'd2666, 32'd3000, 32'd3333};

    initial begin
        int  dc;
        bit  saw_done;
        rst_n    = 1'b0;
        start    = 1'b0;
        adj_mask = 10'd0;
        req_seen = 0;
        setTables(32'h0001_0000, 8'd4, 1);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy_done_err", {busy, done, deg_err}, 3'b000);
        checkOutput("reset_rd_req_idx", {rd_bus.rd_req, rd_bus.rd_idx}, 5'd0);
        checkOutput("reset_partials", orPartials(), 0);
        rst_n = 1'b1;

        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checkOutput("idle_outputs", {busy, done, deg_err, rd_bus.rd_req, rd_bus.rd_idx, orPartials()}, 0);
        end
        checkOutput("idle_no_req", req_seen, 0);

        $display("[TB] pass with empty mask");
        applyStimulus(10'd0, 1'b0, dc);
        checkOutput("mask0_done_cycle", dc, 11);
        checkOutput("mask0_no_req", req_seen, 0);
        checkOutput("mask0_partials", orPartials(), 0);
        @(posedge clk);
        #1;
        checkOutput("mask0_done_pulse_ends", {done, busy}, 2'b00);

        $display("[TB] single linked source 0x10000 / 4");
        applyStimulus(10'b0000000001, 1'b0, dc);
        checkOutput("single_first_req_cycle", first_req_cycle, 1);
        checkOutput("single_first_req_idx", first_req_idx, 0);
        checkOutput("single_p0", pp[0], 32'h0000_4000);
        checkOutput("single_others", orPartials() & ~pp[0], 0);
        checkOutput("single_done_cycle", dc, 45);
        checkOutput("single_req_count", req_seen, 1);

        $display("[TB] all ten linked, pr=1000*(j+1), outdeg=3");
        for (int k = 0; k < 10; k++) begin
            pr_tab[k]  = 32'(1000 * (k + 1));
            deg_tab[k] = 8'd3;
            lat_tab[k] = 1;
        end
        applyStimulus(10'h3FF, 1'b0, dc);
        for (int k = 0; k < 10; k++) checkOutput($sformatf("div3_p%0d", k), pp[k], exp_div3[k]);
        checkOutput("div3_done_cycle", dc, 351);
        checkOutput("div3_tree_sum", sumPartials(), 18330);
        checkOutput("div3_deg_err", deg_err, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("div3_hold_after_done", pp[9], 32'd3333);

        $display("[TB] source 5 reports outdeg 0");
        setTables(32'hFFFF_FFFF, 8'd1, 1);
        deg_tab[5] = 8'd0;
        applyStimulus(10'h3FF, 1'b0, dc);
        for (int k = 0; k < 10; k++)
            checkOutput($sformatf("deg0_p%0d", k), pp[k], (k == 5) ? 32'd0 : 32'hFFFF_FFFF);
        checkOutput("deg0_deg_err", deg_err, 1'b1);
        checkOutput("deg0_done_cycle", dc, 318);
        applyStimulus(10'd0, 1'b0, dc);
        checkOutput("deg0_err_cleared", deg_err, 1'b0);
        checkOutput("deg0_partials_cleared", orPartials(), 0);

        $display("[TB] read latency 5 on source 0");
        setTables(32'h0001_0000, 8'd4, 1);
        lat_tab[0] = 5;
        applyStimulus(10'b0000000001, 1'b0, dc);
        checkOutput("lat5_done_cycle", dc, 49);
        checkOutput("lat5_p0", pp[0], 32'h0000_4000);

        $display("[TB] start pulsed while busy");
        lat_tab[0] = 1;
        applyStimulus(10'b0000000001, 1'b1, dc);
        checkOutput("busy_start_done_cycle", dc, 45);
        checkOutput("busy_start_p0", pp[0], 32'h0000_4000);
        checkOutput("busy_start_req_count", req_seen, 1);

        $display("[TB] reset during division");
        for (int k = 0; k < 10; k++) begin
            pr_tab[k]  = 32'(1000 * (k + 1));
            deg_tab[k] = 8'd3;
        end
        @(posedge clk);
        #1;
        adj_mask = 10'h3FF;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        checkOutput("midpass_state", {busy, rd_bus.rd_idx, pp[0]}, {1'b1, 4'd1, 32'd333});
        rst_n = 1'b0;
        #1;
        checkOutput("midpass_reset_ctrl", {busy, done, deg_err, rd_bus.rd_req, rd_bus.rd_idx}, 0);
        checkOutput("midpass_reset_partials", orPartials(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        checkOutput("midpass_no_done", saw_done, 1'b0);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
